cpu_sequencer: RTL and testbench
================================

# cpu_sequencer

Multi-cycle control unit for the 16-bit CPU core. Fetches instructions over a req/ready memory port, decodes them, and drives the 8×16 register file's read, write and PC-increment ports. Performs ALU, load/store, branch and jump operations internally. Sits between the register file and the memory/bus interface; it is the only master of both.

## Interface
Parameters: none. Data width 16, register address width 3, and register 7 as PC are fixed.
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- o_rf_read_addr1  out  3  register file read port 1 address
- o_rf_read_addr2  out  3  register file read port 2 address
- i_rf_read_data1  in  16  read port 1 data (combinational)
- i_rf_read_data2  in  16  read port 2 data (combinational)
- i_rf_program_counter  in  16  current r7
- o_rf_write_enable  out  1  register file write strobe
- o_rf_write_address  out  3  register file write address
- o_rf_write_data  out  16  register file write data
- o_rf_count_enable  out  1  PC (r7) increment strobe
- o_mem_req  out  1  memory request
- o_mem_we  out  1  1 = store, 0 = read
- o_mem_addr  out  16  word address
- o_mem_wdata  out  16  store data
- i_mem_ready  in  1  transfer completes on a clock edge where req && ready
- i_mem_rdata  in  16  read data, valid when ready
- o_halted  out  1  core stopped (HALT or fault)
- o_fault  out  1  stopped on an illegal opcode

## Operation
- Instruction word: op[15:12], rd[11:9], rs1[8:6], rs2[5:3], imm6[5:0] (sign-extended), imm9[8:0] (zero-extended).
- Opcodes:
  - 0 NOP
  - 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR: rd = rs1 op rs2
  - 6 ADDI: rd = rs1 + imm6
  - 7 LDI: rd = imm9
  - 8 LD: rd = mem[rs1 + imm6]
  - 9 ST: mem[rs1 + imm6] = rd
  - A BEQ: if rd == rs1, PC = PC + imm6
  - B JR: PC = rs1
  - F HALT
  - C, D, E illegal: halt and set fault
- Arithmetic is 16-bit modulo 2^16. There are no flags. Writes to r0 are issued but discarded by the register file.
- States: PC_INIT, FETCH, DECODE, EXEC, MEM, WB, HALT.
- PC_INIT (reset state): write r7 = 0. Always goes to FETCH.
- FETCH: req=1, we=0, addr = i_rf_program_counter. Holds until ready. On the ready cycle: IR ← rdata, o_rf_count_enable=1, go to DECODE.
- DECODE: read_addr1 = rs1. read_addr2 = rd for ST/BEQ, otherwise rs2. At the edge, latch A, B and PC (already incremented).
- EXEC: compute result/address/target into a result register.
  - NOP, and BEQ not taken → FETCH.
  - LD, ST → MEM.
  - HALT, illegal → HALT.
  - All others → WB.
- MEM: req=1, addr = result, we = (ST), wdata = B. Holds until ready. LD latches rdata and goes to WB. ST goes to FETCH.
- WB: one-cycle write. Address is rd, or 7 for BEQ-taken and JR. Then FETCH.
- HALT: all strobes 0, o_halted=1. Held until reset. o_fault=1 only if entered from an illegal opcode.
- The write strobe and count strobe are never asserted in the same cycle.

## Timing
- All strobes and memory outputs are combinational functions of the state and registered data. No combinational path from i_mem_ready to o_mem_req.
- Values asserted during reset and in PC_INIT:
  - o_rf_write_enable=1, o_rf_write_address=7, o_rf_write_data=0
  - o_mem_req=0, o_rf_count_enable=0, o_halted=0, o_fault=0
- First fetch request: the cycle after the first edge following reset release.
- Minimum cycles per instruction with zero-wait memory (ready already high):
  - NOP and BEQ not taken: 3
  - ALU ops, LDI, ADDI, ST, JR, BEQ taken: 4
  - LD: 5
- Each wait cycle (ready=0) extends FETCH/MEM by one cycle. Address, we and wdata stay stable while req=1 and ready=0.
- BEQ target uses the incremented PC, so imm6 = 0 continues to the next instruction. Taken BEQ rewrites r7 in WB.
- Reset asserted mid-transfer: req drops immediately, and the state returns to PC_INIT.

## Test plan
- Reset, then zero-wait memory holding LDI r1,5; LDI r2,3; SUB r3,r1,r2; HALT → r3=2, o_halted=1, o_fault=0. Final PC=4.
- ADD r1,r1,r2 with r1=0xFFFF, r2=2 → r1=0x0001 (wrap). Exactly one write strobe, and it occurs in WB.
- ST r1,[r2+(-1)] with r2=0x10, then LD r4,[r2-1] → store at addr 0x000F with wdata = r1, then r4 = r1. With ready held low for 3 cycles, req/addr are held stable and LD takes 8 cycles.
- BEQ r1,r1,-2 at PC=10 → PC=9. BEQ with unequal operands → PC=11 after 3 cycles. JR r5 with r5=0x1234 → next fetch addr 0x1234.
- Opcode 0xC at PC=0 → o_halted=1 and o_fault=1. No register write, and req stays 0 thereafter.
- Assert i_rst_n low mid-MEM → req=0 immediately. After release, r7 is written to 0 and fetch restarts at addr 0.

Source files
------------

// File: rtl/cpu_sequencer.sv
// Multi-cycle control unit for the 16-bit core: fetches over a req/ready port,
// decodes, executes ALU/load/store/branch/jump, and drives the 8x16 register file.
module cpu_sequencer (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic [2:0]  o_rf_read_addr1,
  output logic [2:0]  o_rf_read_addr2,
  input  logic [15:0] i_rf_read_data1,
  input  logic [15:0] i_rf_read_data2,
  input  logic [15:0] i_rf_program_counter,
  output logic        o_rf_write_enable,
  output logic [2:0]  o_rf_write_address,
  output logic [15:0] o_rf_write_data,
  output logic        o_rf_count_enable,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [15:0] o_mem_addr,
  output logic [15:0] o_mem_wdata,
  input  logic        i_mem_ready,
  input  logic [15:0] i_mem_rdata,
  output logic        o_halted,
  output logic        o_fault
);

  typedef enum logic [2:0] {PC_INIT, FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_ADDI = 4'h6,
    OP_LDI  = 4'h7,
    OP_LD   = 4'h8,
    OP_ST   = 4'h9,
    OP_BEQ  = 4'hA,
    OP_JR   = 4'hB,
    OP_HALT = 4'hF
  } op_t;

  state_t      state_q, state_n;
  logic [15:0] ir_q;
  logic [15:0] a_q, b_q, pc_q, res_q;
  logic        fault_q;

  op_t         op;
  logic [2:0]  rd, rs1, rs2;
  logic [15:0] simm, zimm;
  logic [15:0] exec_res;
  logic        illegal;

  assign op      = op_t'(ir_q[15:12]);
  assign rd      = ir_q[11:9];
  assign rs1     = ir_q[8:6];
  assign rs2     = ir_q[5:3];
  assign simm    = {{10{ir_q[5]}}, ir_q[5:0]};
  assign zimm    = {7'd0, ir_q[8:0]};
  assign illegal = (ir_q[15:12] == 4'hC) || (ir_q[15:12] == 4'hD) || (ir_q[15:12] == 4'hE);

  // ST and BEQ read rd through port 2 so its value lands in B.
  assign o_rf_read_addr1 = rs1;
  assign o_rf_read_addr2 = ((op == OP_ST) || (op == OP_BEQ)) ? rd : rs2;

  always_comb begin
    exec_res = '0;
    case (op)
      OP_ADD:               exec_res = a_q + b_q;
      OP_SUB:               exec_res = a_q - b_q;
      OP_AND:               exec_res = a_q & b_q;
      OP_OR:                exec_res = a_q | b_q;
      OP_XOR:               exec_res = a_q ^ b_q;
      OP_ADDI, OP_LD, OP_ST: exec_res = a_q + simm;
      OP_LDI:               exec_res = zimm;
      OP_BEQ:               exec_res = pc_q + simm;
      OP_JR:                exec_res = a_q;
      default:              exec_res = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= PC_INIT;
    end else begin
      state_q <= state_n;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      pc_q    <= '0;
      res_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      case (state_q)
        FETCH:  if (i_mem_ready) ir_q <= i_mem_rdata;
        DECODE: begin
          a_q  <= i_rf_read_data1;
          b_q  <= i_rf_read_data2;
          pc_q <= i_rf_program_counter;
        end
        EXEC: begin
          res_q <= exec_res;
          if (illegal) fault_q <= 1'b1;
        end
        MEM:    if (i_mem_ready && (op != OP_ST)) res_q <= i_mem_rdata;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n            = state_q;
    o_rf_write_enable  = 1'b0;
    o_rf_write_address = '0;
    o_rf_write_data    = '0;
    o_rf_count_enable  = 1'b0;
    o_mem_req          = 1'b0;
    o_mem_we           = 1'b0;
    o_mem_addr         = '0;
    o_mem_wdata        = '0;
    o_halted           = 1'b0;
    o_fault            = 1'b0;
    case (state_q)
      PC_INIT: begin
        o_rf_write_enable  = 1'b1;
        o_rf_write_address = 3'd7;
        o_rf_write_data    = '0;
        state_n            = FETCH;
      end
      FETCH: begin
        o_mem_req  = 1'b1;
        o_mem_addr = i_rf_program_counter;
        if (i_mem_ready) begin
          o_rf_count_enable = 1'b1;
          state_n           = DECODE;
        end
      end
      DECODE: state_n = EXEC;
      EXEC: begin
        case (op)
          OP_NOP:       state_n = FETCH;
          OP_BEQ:       state_n = (a_q == b_q) ? WB : FETCH;
          OP_LD, OP_ST: state_n = MEM;
          OP_HALT:      state_n = HALT;
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
          OP_ADDI, OP_LDI, OP_JR: state_n = WB;
          default:      state_n = HALT;
        endcase
      end
      MEM: begin
        o_mem_req   = 1'b1;
        o_mem_we    = (op == OP_ST);
        o_mem_addr  = res_q;
        o_mem_wdata = b_q;
        if (i_mem_ready) state_n = (op == OP_ST) ? FETCH : WB;
      end
      WB: begin
        o_rf_write_enable  = 1'b1;
        o_rf_write_address = ((op == OP_BEQ) || (op == OP_JR)) ? 3'd7 : rd;
        o_rf_write_data    = res_q;
        state_n            = FETCH;
      end
      HALT: begin
        o_halted = 1'b1;
        o_fault  = fault_q;
      end
      default: state_n = PC_INIT;
    endcase
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: register file / 256-word memory environment, an
// instruction-level timing model producing a per-cycle expected trace, and literal pins.
module tb_cpu_sequencer;
  localparam int MAXC = 128;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [2:0]  o_rf_read_addr1, o_rf_read_addr2;
  logic [15:0] i_rf_read_data1, i_rf_read_data2, i_rf_program_counter;
  logic        o_rf_write_enable;
  logic [2:0]  o_rf_write_address;
  logic [15:0] o_rf_write_data;
  logic        o_rf_count_enable;
  logic        o_mem_req, o_mem_we;
  logic [15:0] o_mem_addr, o_mem_wdata;
  logic        i_mem_ready = 1'b0;
  logic [15:0] i_mem_rdata;
  logic        o_halted, o_fault;

  cpu_sequencer dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .o_rf_read_addr1(o_rf_read_addr1), .o_rf_read_addr2(o_rf_read_addr2),
    .i_rf_read_data1(i_rf_read_data1), .i_rf_read_data2(i_rf_read_data2),
    .i_rf_program_counter(i_rf_program_counter),
    .o_rf_write_enable(o_rf_write_enable), .o_rf_write_address(o_rf_write_address),
    .o_rf_write_data(o_rf_write_data), .o_rf_count_enable(o_rf_count_enable),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_ready(i_mem_ready), .i_mem_rdata(i_mem_rdata),
    .o_halted(o_halted), .o_fault(o_fault)
  );

  always #5 i_clk = ~i_clk;

  logic [15:0] rf [8];
  logic [15:0] mem [256];
  logic [15:0] preset [8];
  logic [15:0] prog [256];
  int          waits [32];

  assign i_rf_read_data1      = rf[o_rf_read_addr1];
  assign i_rf_read_data2      = rf[o_rf_read_addr2];
  assign i_rf_program_counter = rf[7];
  assign i_mem_rdata          = mem[o_mem_addr[7:0]];

  // Environment: register file (r0 discards writes) and memory aliased mod 256.
  always @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 8; i++) rf[i] <= preset[i];
      for (int i = 0; i < 256; i++) mem[i] <= prog[i];
    end else begin
      if (o_rf_write_enable && (o_rf_write_address != 3'd0)) rf[o_rf_write_address] <= o_rf_write_data;
      if (o_rf_count_enable) rf[7] <= rf[7] + 16'd1;
      if (o_mem_req && i_mem_ready && o_mem_we) mem[o_mem_addr[7:0]] <= o_mem_wdata;
    end
  end

  // Ready generator: request n is held off for waits[n] cycles.
  int reqn, wcnt;
  initial begin
    reqn = 0;
    wcnt = 0;
    forever begin
      @(negedge i_clk);
      if (!i_rst_n) begin
        reqn = 0;
        wcnt = 0;
        i_mem_ready = 1'b0;
      end else if (o_mem_req) begin
        if (wcnt >= waits[reqn]) begin
          i_mem_ready = 1'b1;
          reqn++;
          wcnt = 0;
        end else begin
          i_mem_ready = 1'b0;
          wcnt++;
        end
      end else begin
        i_mem_ready = 1'b0;
      end
    end
  end

  int n_checks = 0;
  int n_fail = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endfunction

  // Expected per-cycle trace; cycle 0 is the PC_INIT cycle after reset release.
  bit          e_req [MAXC], e_we [MAXC], e_wen [MAXC], e_cnt [MAXC], e_halt [MAXC], e_fault [MAXC];
  logic [15:0] e_addr [MAXC], e_wd [MAXC], e_wdat [MAXC];
  logic [2:0]  e_waddr [MAXC];
  int          hcyc;

  task automatic mem_phase(inout int c, inout int rq, input logic [15:0] ea, input bit we, input logic [15:0] wd);
    for (int k = 0; k <= waits[rq]; k++) begin
      e_req[c+k]  = 1'b1;
      e_we[c+k]   = we;
      e_addr[c+k] = ea;
      e_wd[c+k]   = wd;
    end
    c  = c + waits[rq] + 1;
    rq = rq + 1;
  endtask

  task automatic build_trace();
    logic [15:0] r [8];
    logic [15:0] m [256];
    logic [15:0] ir, pc, a, simm, res, ea;
    logic [3:0]  op;
    logic [2:0]  rd, rs1, rs2, wa;
    int          c, rq;
    bit          done, flt, do_wb;
    for (int i = 0; i < MAXC; i++) begin
      e_req[i] = 0; e_we[i] = 0; e_wen[i] = 0; e_cnt[i] = 0; e_halt[i] = 0; e_fault[i] = 0;
      e_addr[i] = '0; e_wd[i] = '0; e_wdat[i] = '0; e_waddr[i] = '0;
    end
    r = preset;
    m = prog;
    e_wen[0] = 1'b1; e_waddr[0] = 3'd7; e_wdat[0] = 16'd0;
    r[7] = 16'd0;
    c = 1; rq = 0; done = 0; flt = 0;
    while (!done && c < MAXC - 24) begin
      pc = r[7];
      for (int k = 0; k <= waits[rq]; k++) begin
        e_req[c+k] = 1'b1;
        e_addr[c+k] = pc;
      end
      c = c + waits[rq];
      rq++;
      e_cnt[c] = 1'b1;
      ir = m[pc[7:0]];
      r[7] = pc + 16'd1;
      c = c + 3;
      op = ir[15:12]; rd = ir[11:9]; rs1 = ir[8:6]; rs2 = ir[5:3];
      simm = {{10{ir[5]}}, ir[5:0]};
      a = r[rs1];
      wa = rd; do_wb = 0; res = '0;
      case (op)
        4'h0: ;
        4'h1: begin res = a + r[rs2]; do_wb = 1; end
        4'h2: begin res = a - r[rs2]; do_wb = 1; end
        4'h3: begin res = a & r[rs2]; do_wb = 1; end
        4'h4: begin res = a | r[rs2]; do_wb = 1; end
        4'h5: begin res = a ^ r[rs2]; do_wb = 1; end
        4'h6: begin res = a + simm; do_wb = 1; end
        4'h7: begin res = {7'd0, ir[8:0]}; do_wb = 1; end
        4'h8: begin
          ea = a + simm;
          mem_phase(c, rq, ea, 1'b0, 16'd0);
          res = m[ea[7:0]];
          do_wb = 1;
        end
        4'h9: begin
          ea = a + simm;
          mem_phase(c, rq, ea, 1'b1, r[rd]);
          m[ea[7:0]] = r[rd];
        end
        4'hA: if (r[rd] == a) begin res = r[7] + simm; wa = 3'd7; do_wb = 1; end
        4'hB: begin res = a; wa = 3'd7; do_wb = 1; end
        4'hF: done = 1;
        default: begin done = 1; flt = 1; end
      endcase
      if (do_wb) begin
        e_wen[c] = 1'b1; e_waddr[c] = wa; e_wdat[c] = res;
        if (wa != 3'd0) r[wa] = res;
        c++;
      end
    end
    hcyc = c;
    for (int i = c; i < MAXC; i++) begin
      e_halt[i] = 1'b1;
      e_fault[i] = flt;
    end
  endtask

  int cyc = 0;
  bit tracing = 0;
  int wen_n, wen_cyc, req_n;
  int fetch_addr [$];
  int fetch_cyc [$];

  initial begin
    forever begin
      @(negedge i_clk);
      #1;
      if (!i_rst_n) begin
        cyc = 0; wen_n = 0; wen_cyc = -1; req_n = 0;
        fetch_addr.delete();
        fetch_cyc.delete();
        chk("rst_wen", o_rf_write_enable, 1);
        chk("rst_waddr", o_rf_write_address, 7);
        chk("rst_wdata", o_rf_write_data, 0);
        chk("rst_req", o_mem_req, 0);
        chk("rst_cnt", o_rf_count_enable, 0);
        chk("rst_halted", o_halted, 0);
        chk("rst_fault", o_fault, 0);
      end else if (tracing && cyc < MAXC) begin
        chk("req", o_mem_req, e_req[cyc]);
        if (e_req[cyc]) begin
          chk("mem_we", o_mem_we, e_we[cyc]);
          chk("mem_addr", o_mem_addr, e_addr[cyc]);
          if (e_we[cyc]) chk("mem_wdata", o_mem_wdata, e_wd[cyc]);
        end
        chk("rf_wen", o_rf_write_enable, e_wen[cyc]);
        if (e_wen[cyc]) begin
          chk("rf_waddr", o_rf_write_address, e_waddr[cyc]);
          chk("rf_wdata", o_rf_write_data, e_wdat[cyc]);
        end
        chk("rf_cnt", o_rf_count_enable, e_cnt[cyc]);
        chk("halted", o_halted, e_halt[cyc]);
        chk("fault", o_fault, e_fault[cyc]);
        chk("wen_cnt_excl", o_rf_write_enable && o_rf_count_enable, 0);
        if (o_mem_req) req_n++;
        if (o_rf_write_enable && cyc > 0) begin wen_n++; wen_cyc = cyc; end
        if (o_rf_count_enable) begin fetch_addr.push_back(o_mem_addr); fetch_cyc.push_back(cyc); end
        cyc++;
      end
    end
  end

  function automatic int qget(input int q [$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic clear_setup();
    for (int i = 0; i < 8; i++) preset[i] = 16'd0;
    preset[7] = 16'h7777;
    for (int i = 0; i < 256; i++) prog[i] = 16'h0000;
    for (int i = 0; i < 32; i++) waits[i] = 0;
  endtask

  task automatic start();
    tracing = 0;
    i_rst_n = 1'b0;
    repeat (3) @(posedge i_clk);
    build_trace();
    #2;
    i_rst_n = 1'b1;
    tracing = 1;
  endtask

  task automatic wait_cyc(input int target);
    int guard = 0;
    while (cyc < target && guard < MAXC + 10) begin
      @(negedge i_clk);
      #2;
      guard++;
    end
    if (cyc < target) chk("run_timeout", cyc, target);
  endtask

  task automatic run();
    start();
    wait_cyc(hcyc + 3);
    tracing = 0;
  endtask

  initial begin
    // LDI r1,5; LDI r2,3; SUB r3,r1,r2; HALT
    clear_setup();
    prog[0] = 16'h7205; prog[1] = 16'h7403; prog[2] = 16'h2650; prog[3] = 16'hF000;
    run();
    chk("t1_r3", rf[3], 16'd2);
    chk("t1_pc", rf[7], 16'd4);
    chk("t1_halted", o_halted, 1);
    chk("t1_fault", o_fault, 0);
    chk("t1_ldi_cycles", qget(fetch_cyc, 1) - qget(fetch_cyc, 0), 4);

    // ADD r1,r1,r2 wrap
    clear_setup();
    preset[1] = 16'hFFFF; preset[2] = 16'd2;
    prog[0] = 16'h1250; prog[1] = 16'hF000;
    run();
    chk("t2_r1", rf[1], 16'h0001);
    chk("t2_wen_count", wen_n, 1);
    chk("t2_wen_cycle", wen_cyc, 4);

    // ST r1,[r2-1]; LD r4,[r2-1] with 3 wait cycles on the load
    clear_setup();
    preset[1] = 16'hBEEF; preset[2] = 16'h0010;
    prog[0] = 16'h92BF; prog[1] = 16'h88BF; prog[2] = 16'hF000;
    waits[3] = 3;
    run();
    chk("t3_mem", mem[15], 16'hBEEF);
    chk("t3_r4", rf[4], 16'hBEEF);
    chk("t3_st_cycles", qget(fetch_cyc, 1) - qget(fetch_cyc, 0), 4);
    chk("t3_ld_cycles", qget(fetch_cyc, 2) - qget(fetch_cyc, 1), 8);

    // JR r5 -> 10; BEQ r1,r1,-2 -> 9; HALT
    clear_setup();
    preset[5] = 16'd10;
    prog[0] = 16'hB140; prog[10] = 16'hA27E; prog[9] = 16'hF000;
    run();
    chk("t4_beq_target", qget(fetch_addr, 2), 9);
    chk("t4_beq_cycles", qget(fetch_cyc, 2) - qget(fetch_cyc, 1), 4);
    chk("t4_pc", rf[7], 16'd10);

    // JR r6 -> 10; BEQ r1,r2,5 not taken; JR r5 -> 0x1234; HALT
    clear_setup();
    preset[1] = 16'd1; preset[2] = 16'd2; preset[5] = 16'h1234; preset[6] = 16'd10;
    prog[0] = 16'hB180; prog[10] = 16'hA285; prog[11] = 16'hB140; prog[8'h34] = 16'hF000;
    run();
    chk("t5_beq_nt_addr", qget(fetch_addr, 2), 11);
    chk("t5_beq_nt_cycles", qget(fetch_cyc, 2) - qget(fetch_cyc, 1), 3);
    chk("t5_jr_addr", qget(fetch_addr, 3), 16'h1234);
    chk("t5_pc", rf[7], 16'h1235);

    // Illegal opcode at PC 0
    clear_setup();
    prog[0] = 16'hC000;
    run();
    chk("t6_halted", o_halted, 1);
    chk("t6_fault", o_fault, 1);
    chk("t6_no_write", wen_n, 0);
    chk("t6_req_cycles", req_n, 1);

    // Reset asserted while a store waits in MEM
    clear_setup();
    preset[1] = 16'h55AA; preset[2] = 16'h0010;
    prog[0] = 16'h92BF; prog[1] = 16'hF000;
    waits[1] = 10;
    start();
    wait_cyc(6);
    chk("t7_req_before", o_mem_req, 1);
    tracing = 0;
    i_rst_n = 1'b0;
    #1;
    chk("t7_req_drop", o_mem_req, 0);
    chk("t7_wen_in_reset", o_rf_write_enable, 1);
    waits[1] = 0;
    run();
    chk("t7_first_fetch", qget(fetch_addr, 0), 0);
    chk("t7_mem", mem[15], 16'h55AA);
    chk("t7_pc", rf[7], 16'd2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
